// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - memory handshake and control bundle for the multi-cycle RV32I controller
// The trap signal exists only when ILLEGAL_TRAP_EN is defined.
interface multicycle_control_unit_if #(
  parameter int XLEN     = 32,
  parameter int ALUCTR_W = 5
);
  logic [31:0]         inst;
  logic                imem_ready;
  logic                dmem_ready;
  logic                alu_zero;
  logic                imem_req;
  logic                dmem_req;
  logic                IRWr;
  logic                PCWr;
  logic [1:0]          PCSrc;
  logic                RegWr;
  logic                ALUASrc;
  logic [1:0]          ALUBSrc;
  logic [ALUCTR_W-1:0] ALUCtr;
  logic [2:0]          ExtOp;
  logic [XLEN-1:0]     imm_out;
  logic                Branch;
  logic                MemtoReg;
  logic                MemWr;
  logic [2:0]          MemOp;
  logic                bus_err;
`ifdef ILLEGAL_TRAP_EN
  logic                trap;
`endif

  // Controller side: consumes memory/ALU status, drives requests and datapath controls
  modport master (
    input  inst, imem_ready, dmem_ready, alu_zero,
    output imem_req, dmem_req, IRWr, PCWr, PCSrc, RegWr, ALUASrc, ALUBSrc,
    output ALUCtr, ExtOp, imm_out, Branch, MemtoReg, MemWr, MemOp, bus_err
`ifdef ILLEGAL_TRAP_EN
    , output trap
`endif
  );

  // Datapath/memory side
  modport slave (
    output inst, imem_ready, dmem_ready, alu_zero,
    input  imem_req, dmem_req, IRWr, PCWr, PCSrc, RegWr, ALUASrc, ALUBSrc,
    input  ALUCtr, ExtOp, imm_out, Branch, MemtoReg, MemWr, MemOp, bus_err
`ifdef ILLEGAL_TRAP_EN
    , input trap
`endif
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - FETCH/DECODE/EXEC/MEM/WB controller for a multi-cycle RV32I datapath
// Optional feature: ILLEGAL_TRAP_EN (illegal instructions park the FSM in TRAP instead of executing as NOP).
module multicycle_control_unit #(
  parameter int XLEN        = 32,
  parameter int ALUCTR_W    = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                       clk,
  input logic                       rst,
  multicycle_control_unit_if.master io_bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] EXT_I = 3'b001;
  localparam logic [2:0] EXT_B = 3'b010;
  localparam logic [2:0] EXT_J = 3'b011;
  localparam logic [2:0] EXT_U = 3'b100;
  localparam logic [2:0] EXT_S = 3'b101;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;
  localparam logic [1:0] PC_JALR   = 2'b11;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [31:0]         r_ir;
  logic [7:0]          r_cnt;

  // Latched per-instruction control fields, stable from DECODE to the next DECODE
  logic [ALUCTR_W-1:0] r_aluctr;
  logic [2:0]          r_extop;
  logic [2:0]          r_memop;
  logic [XLEN-1:0]     r_imm;
  logic                r_asrc;
  logic [1:0]          r_bsrc;
  logic                r_branch;
  logic                r_load;
  logic                r_store;
  logic                r_jal;
  logic                r_jalr;
  logic                r_illegal;

  // Decoder results from the captured instruction word
  logic [6:0]          w_opcode;
  logic [2:0]          w_funct3;
  logic [6:0]          w_funct7;
  logic [31:0]         w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [4:0]          w_dec_aluctr;
  logic [2:0]          w_dec_extop;
  logic [2:0]          w_dec_memop;
  logic [31:0]         w_dec_imm;
  logic                w_dec_asrc;
  logic [1:0]          w_dec_bsrc;
  logic                w_dec_branch, w_dec_load, w_dec_store, w_dec_jal, w_dec_jalr;
  logic                w_dec_illegal;

  // Per-state strobes
  logic                w_expire;
  logic                w_imem_req, w_dmem_req, w_irwr, w_pcwr, w_regwr, w_memwr, w_bus_err;
  logic [1:0]          w_pcsrc;

  assign w_opcode = r_ir[6:0];
  assign w_funct3 = r_ir[14:12];
  assign w_funct7 = r_ir[31:25];

  assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_u = {r_ir[31:12], 12'b0};
  assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

  // The last waiting cycle of a FETCH or MEM handshake window
  assign w_expire = (r_cnt == TIMEOUT_LAST);

  // Decode the captured instruction into control fields; illegal encodings clear everything
  always_comb begin
    w_dec_aluctr  = 5'h00;
    w_dec_extop   = 3'b000;
    w_dec_memop   = 3'b000;
    w_dec_imm     = 32'd0;
    w_dec_asrc    = 1'b0;
    w_dec_bsrc    = 2'b00;
    w_dec_branch  = 1'b0;
    w_dec_load    = 1'b0;
    w_dec_store   = 1'b0;
    w_dec_jal     = 1'b0;
    w_dec_jalr    = 1'b0;
    w_dec_illegal = 1'b0;
    case (w_opcode)
      OP_LUI: begin
        w_dec_aluctr = 5'h10;
        w_dec_extop  = EXT_U;
        w_dec_imm    = w_imm_u;
        w_dec_asrc   = 1'b1;
      end
      OP_AUIPC: begin
        w_dec_extop = EXT_U;
        w_dec_imm   = w_imm_u;
        w_dec_asrc  = 1'b1;
        w_dec_bsrc  = 2'b10;
      end
      OP_JAL: begin
        w_dec_extop = EXT_J;
        w_dec_imm   = w_imm_j;
        w_dec_asrc  = 1'b1;
        w_dec_bsrc  = 2'b10;
        w_dec_jal   = 1'b1;
      end
      OP_JALR: begin
        w_dec_extop   = EXT_I;
        w_dec_imm     = w_imm_i;
        w_dec_bsrc    = 2'b10;
        w_dec_jalr    = 1'b1;
        w_dec_illegal = (w_funct3 != 3'b000);
      end
      OP_BRANCH: begin
        w_dec_extop  = EXT_B;
        w_dec_imm    = w_imm_b;
        w_dec_branch = 1'b1;
        case (w_funct3)
          3'b000:  w_dec_aluctr = 5'h0A;
          3'b001:  w_dec_aluctr = 5'h0B;
          3'b100:  w_dec_aluctr = 5'h0C;
          3'b101:  w_dec_aluctr = 5'h0D;
          3'b110:  w_dec_aluctr = 5'h0E;
          3'b111:  w_dec_aluctr = 5'h0F;
          default: w_dec_illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        w_dec_extop = EXT_I;
        w_dec_imm   = w_imm_i;
        w_dec_load  = 1'b1;
        case (w_funct3)
          3'b000:  w_dec_memop = 3'b000;
          3'b001:  w_dec_memop = 3'b001;
          3'b010:  w_dec_memop = 3'b010;
          3'b100:  w_dec_memop = 3'b011;
          3'b101:  w_dec_memop = 3'b100;
          default: w_dec_illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        w_dec_extop = EXT_S;
        w_dec_imm   = w_imm_s;
        w_dec_store = 1'b1;
        case (w_funct3)
          3'b000:  w_dec_memop = 3'b000;
          3'b001:  w_dec_memop = 3'b001;
          3'b010:  w_dec_memop = 3'b010;
          default: w_dec_illegal = 1'b1;
        endcase
      end
      OP_IMM: begin
        w_dec_extop = EXT_I;
        w_dec_imm   = w_imm_i;
        case (w_funct3)
          3'b001: begin
            w_dec_aluctr  = 5'h01;
            w_dec_illegal = (w_funct7 != 7'h00);
          end
          3'b101: begin
            if (w_funct7 == 7'h00) w_dec_aluctr = 5'h05;
            else if (w_funct7 == 7'h20) w_dec_aluctr = 5'h09;
            else w_dec_illegal = 1'b1;
          end
          default: w_dec_aluctr = {2'b00, w_funct3};
        endcase
      end
      OP_REG: begin
        if (w_funct7 == 7'h00) w_dec_aluctr = {2'b00, w_funct3};
        else if (w_funct7 == 7'h20 && w_funct3 == 3'b000) w_dec_aluctr = 5'h08;
        else if (w_funct7 == 7'h20 && w_funct3 == 3'b101) w_dec_aluctr = 5'h09;
        else w_dec_illegal = 1'b1;
      end
      default: w_dec_illegal = 1'b1;
    endcase
    if (w_dec_illegal) begin
      w_dec_aluctr = 5'h00;
      w_dec_extop  = 3'b000;
      w_dec_memop  = 3'b000;
      w_dec_imm    = 32'd0;
      w_dec_asrc   = 1'b0;
      w_dec_bsrc   = 2'b00;
      w_dec_branch = 1'b0;
      w_dec_load   = 1'b0;
      w_dec_store  = 1'b0;
      w_dec_jal    = 1'b0;
      w_dec_jalr   = 1'b0;
    end
  end

  // Next-state and strobe generation; handshake strobes qualify with ready in the same cycle
  always_comb begin
    w_state_next = r_state;
    w_imem_req   = 1'b0;
    w_dmem_req   = 1'b0;
    w_irwr       = 1'b0;
    w_pcwr       = 1'b0;
    w_pcsrc      = PC_SEQ;
    w_regwr      = 1'b0;
    w_memwr      = 1'b0;
    w_bus_err    = 1'b0;
    case (r_state)
      S_IDLE: w_state_next = S_FETCH;
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (io_bus.imem_ready) begin
          w_irwr       = 1'b1;
          w_state_next = S_DECODE;
        end else if (w_expire) begin
          w_bus_err    = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
        w_state_next = w_dec_illegal ? S_TRAP : S_EXEC;
`else
        w_state_next = S_EXEC;
`endif
      end
      S_EXEC: begin
        if (r_illegal) begin
          w_pcwr       = 1'b1;
          w_state_next = S_FETCH;
        end else if (r_branch) begin
          w_pcwr       = 1'b1;
          w_pcsrc      = io_bus.alu_zero ? PC_BRANCH : PC_SEQ;
          w_state_next = S_FETCH;
        end else if (r_load || r_store) begin
          w_state_next = S_MEM;
        end else begin
          w_state_next = S_WB;
        end
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        w_memwr    = r_store;
        if (io_bus.dmem_ready) begin
          if (r_load) begin
            w_state_next = S_WB;
          end else begin
            w_pcwr       = 1'b1;
            w_state_next = S_FETCH;
          end
        end else if (w_expire) begin
          w_bus_err    = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_WB: begin
        w_regwr      = 1'b1;
        w_pcwr       = 1'b1;
        w_pcsrc      = r_jal ? PC_JAL : (r_jalr ? PC_JALR : PC_SEQ);
        w_state_next = S_FETCH;
      end
      S_TRAP:  w_state_next = S_TRAP;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Handshake wait counter: counts while a FETCH/MEM wait continues, clears on any exit or retry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if ((r_state == S_FETCH || r_state == S_MEM) && w_state_next == r_state && !w_bus_err) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= 8'd0;
    end
  end

  // Capture the instruction word when the fetch handshake completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_ir <= 32'd0;
    else if (w_irwr) r_ir <= io_bus.inst;
  end

  // Latch decoded control fields at the end of DECODE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aluctr  <= '0;
      r_extop   <= 3'b000;
      r_memop   <= 3'b000;
      r_imm     <= '0;
      r_asrc    <= 1'b0;
      r_bsrc    <= 2'b00;
      r_branch  <= 1'b0;
      r_load    <= 1'b0;
      r_store   <= 1'b0;
      r_jal     <= 1'b0;
      r_jalr    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_aluctr  <= ALUCTR_W'(w_dec_aluctr);
      r_extop   <= w_dec_extop;
      r_memop   <= w_dec_memop;
      r_imm     <= XLEN'($signed(w_dec_imm));
      r_asrc    <= w_dec_asrc;
      r_bsrc    <= w_dec_bsrc;
      r_branch  <= w_dec_branch;
      r_load    <= w_dec_load;
      r_store   <= w_dec_store;
      r_jal     <= w_dec_jal;
      r_jalr    <= w_dec_jalr;
      r_illegal <= w_dec_illegal;
    end
  end

  assign io_bus.imem_req = w_imem_req;
  assign io_bus.dmem_req = w_dmem_req;
  assign io_bus.IRWr     = w_irwr;
  assign io_bus.PCWr     = w_pcwr;
  assign io_bus.PCSrc    = w_pcsrc;
  assign io_bus.RegWr    = w_regwr;
  assign io_bus.MemWr    = w_memwr;
  assign io_bus.bus_err  = w_bus_err;
  assign io_bus.ALUASrc  = r_asrc;
  assign io_bus.ALUBSrc  = r_bsrc;
  assign io_bus.ALUCtr   = r_aluctr;
  assign io_bus.ExtOp    = r_extop;
  assign io_bus.imm_out  = r_imm;
  assign io_bus.Branch   = r_branch;
  assign io_bus.MemtoReg = r_load;
  assign io_bus.MemOp    = r_memop;
`ifdef ILLEGAL_TRAP_EN
  assign io_bus.trap     = (r_state == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_control_unit_if #(.XLEN(32), .ALUCTR_W(5)) bus ();

  multicycle_control_unit #(.XLEN(32), .ALUCTR_W(5), .MEM_TIMEOUT(15)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  alu;
    logic [2:0]  ext;
    logic [2:0]  mop;
    logic [31:0] imm;
  } dec_vec_t;

  task automatic drive_idle();
    bus.inst = 32'd0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.alu_zero = 1'b0;
  endtask

  // Leaves the DUT in the first FETCH cycle with a cleared wait counter
  task automatic do_reset();
    drive_idle(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  // From FETCH: complete the fetch immediately, pass DECODE, return in EXEC
  task automatic fetch_decode(input logic [31:0] i);
    bus.inst = i; bus.imem_ready = 1'b1;
    @(negedge clk); bus.imem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; drive_idle();
    @(negedge clk); #1;
    n_vec++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rst_imem_req got=%b exp=0", bus.imem_req); end
    n_vec++; if (bus.IRWr !== 1'b0) begin n_err++; $display("FAIL rst_irwr got=%b exp=0", bus.IRWr); end
    n_vec++; if (bus.PCWr !== 1'b0) begin n_err++; $display("FAIL rst_pcwr got=%b exp=0", bus.PCWr); end
    n_vec++; if (bus.ALUCtr !== 5'h00) begin n_err++; $display("FAIL rst_aluctr got=%h exp=00", bus.ALUCtr); end
    n_vec++; if (bus.imm_out !== 32'h0) begin n_err++; $display("FAIL rst_imm got=%h exp=0", bus.imm_out); end
    @(negedge clk); rst = 1'b0; #1;
    n_vec++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL idle_imem_req got=%b exp=0", bus.imem_req); end
    @(negedge clk); #1;
    n_vec++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL fetch_after_idle got=%b exp=1", bus.imem_req); end
  endtask

  task automatic test_add();
    do_reset();
    bus.inst = 32'h002081B3; bus.imem_ready = 1'b1; #1;
    n_vec++; if (bus.IRWr !== 1'b1) begin n_err++; $display("FAIL add_irwr_c1 got=%b exp=1", bus.IRWr); end
    @(negedge clk); bus.imem_ready = 1'b0; #1;
    n_vec++; if (bus.IRWr !== 1'b0 || bus.PCWr !== 1'b0) begin n_err++; $display("FAIL add_decode_strobes got=%b%b exp=00", bus.IRWr, bus.PCWr); end
    @(negedge clk); #1;
    n_vec++; if (bus.ALUCtr !== 5'h00) begin n_err++; $display("FAIL add_aluctr got=%h exp=00", bus.ALUCtr); end
    n_vec++; if (bus.RegWr !== 1'b0 || bus.PCWr !== 1'b0) begin n_err++; $display("FAIL add_exec_strobes got=%b%b exp=00", bus.RegWr, bus.PCWr); end
    @(negedge clk); #1;
    n_vec++; if (bus.RegWr !== 1'b1 || bus.PCWr !== 1'b1) begin n_err++; $display("FAIL add_wb_c4 got=%b%b exp=11", bus.RegWr, bus.PCWr); end
    n_vec++; if (bus.PCSrc !== 2'b00) begin n_err++; $display("FAIL add_pcsrc got=%b exp=00", bus.PCSrc); end
    @(negedge clk); #1;
    n_vec++; if (bus.imem_req !== 1'b1 || bus.RegWr !== 1'b0) begin n_err++; $display("FAIL add_refetch got=%b%b exp=10", bus.imem_req, bus.RegWr); end
  endtask

  task automatic test_decode_table();
    dec_vec_t tbl[$];
    tbl.push_back('{32'h402081B3, 5'h08, 3'b000, 3'b000, 32'h00000000}); // sub
    tbl.push_back('{32'h123452B7, 5'h10, 3'b100, 3'b000, 32'h12345000}); // lui
    tbl.push_back('{32'hFFF00093, 5'h00, 3'b001, 3'b000, 32'hFFFFFFFF}); // addi -1
    tbl.push_back('{32'hFFE0D283, 5'h00, 3'b001, 3'b100, 32'hFFFFFFFE}); // lhu -2
    tbl.push_back('{32'h4030D093, 5'h09, 3'b001, 3'b000, 32'h00000403}); // srai
    tbl.push_back('{32'h0020F463, 5'h0F, 3'b010, 3'b000, 32'h00000008}); // bgeu
    tbl.push_back('{32'h0020C463, 5'h0C, 3'b010, 3'b000, 32'h00000008}); // blt
    tbl.push_back('{32'h010000EF, 5'h00, 3'b011, 3'b000, 32'h00000010}); // jal 16
    tbl.push_back('{32'h0020A423, 5'h00, 3'b101, 3'b010, 32'h00000008}); // sw
    tbl.push_back('{32'h0020B1B3, 5'h03, 3'b000, 3'b000, 32'h00000000}); // sltu
    foreach (tbl[i]) begin
      do_reset();
      fetch_decode(tbl[i].inst); #1;
      n_vec++; if (bus.ALUCtr !== tbl[i].alu) begin n_err++; $display("FAIL dec%0d_aluctr got=%h exp=%h", i, bus.ALUCtr, tbl[i].alu); end
      n_vec++; if (bus.ExtOp !== tbl[i].ext) begin n_err++; $display("FAIL dec%0d_extop got=%b exp=%b", i, bus.ExtOp, tbl[i].ext); end
      n_vec++; if (bus.MemOp !== tbl[i].mop) begin n_err++; $display("FAIL dec%0d_memop got=%b exp=%b", i, bus.MemOp, tbl[i].mop); end
      n_vec++; if (bus.imm_out !== tbl[i].imm) begin n_err++; $display("FAIL dec%0d_imm got=%h exp=%h", i, bus.imm_out, tbl[i].imm); end
    end
  endtask

  task automatic test_load_wait();
    int req_cycles = 0;
    do_reset();
    fetch_decode(32'h0080A283); #1;
    n_vec++; if (bus.MemOp !== 3'b010) begin n_err++; $display("FAIL lw_memop got=%b exp=010", bus.MemOp); end
    n_vec++; if (bus.imm_out !== 32'd8) begin n_err++; $display("FAIL lw_imm got=%h exp=8", bus.imm_out); end
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      bus.dmem_ready = (k == 4); #1;
      if (bus.dmem_req === 1'b1) req_cycles++;
      n_vec++; if (bus.MemWr !== 1'b0 || bus.RegWr !== 1'b0) begin n_err++; $display("FAIL lw_mem%0d_strobes got=%b%b exp=00", k, bus.MemWr, bus.RegWr); end
      @(negedge clk);
    end
    bus.dmem_ready = 1'b0; #1;
    n_vec++; if (req_cycles != 4) begin n_err++; $display("FAIL lw_req_cycles got=%0d exp=4", req_cycles); end
    n_vec++; if (bus.RegWr !== 1'b1 || bus.MemtoReg !== 1'b1) begin n_err++; $display("FAIL lw_wb got=%b%b exp=11", bus.RegWr, bus.MemtoReg); end
    n_vec++; if (bus.PCWr !== 1'b1 || bus.PCSrc !== 2'b00 || bus.dmem_req !== 1'b0) begin n_err++; $display("FAIL lw_wb_pc got=%b%b%b exp=1000", bus.PCWr, bus.PCSrc, bus.dmem_req); end
  endtask

  task automatic test_branch();
    logic [1:0] exp_src;
    for (int az = 1; az >= 0; az--) begin
      exp_src = (az == 1) ? 2'b01 : 2'b00;
      do_reset();
      fetch_decode(32'h00208463);
      bus.alu_zero = 1'(az); #1;
      n_vec++; if (bus.imm_out !== 32'd8) begin n_err++; $display("FAIL beq%0d_imm got=%h exp=8", az, bus.imm_out); end
      n_vec++; if (bus.ALUCtr !== 5'h0A || bus.Branch !== 1'b1) begin n_err++; $display("FAIL beq%0d_ctl got=%h/%b exp=0a/1", az, bus.ALUCtr, bus.Branch); end
      n_vec++; if (bus.PCWr !== 1'b1 || bus.PCSrc !== exp_src) begin n_err++; $display("FAIL beq%0d_pc got=%b/%b exp=1/%b", az, bus.PCWr, bus.PCSrc, exp_src); end
      @(negedge clk); bus.alu_zero = 1'b0; #1;
      n_vec++; if (bus.imem_req !== 1'b1 || bus.RegWr !== 1'b0) begin n_err++; $display("FAIL beq%0d_refetch got=%b%b exp=10", az, bus.imem_req, bus.RegWr); end
    end
  endtask

  task automatic test_jump();
    logic [31:0] insts [2];
    logic [1:0]  srcs  [2];
    logic [31:0] imms  [2];
    insts[0] = 32'h010000EF; srcs[0] = 2'b10; imms[0] = 32'd16;
    insts[1] = 32'h004100E7; srcs[1] = 2'b11; imms[1] = 32'd4;
    for (int j = 0; j < 2; j++) begin
      do_reset();
      fetch_decode(insts[j]); #1;
      n_vec++; if (bus.imm_out !== imms[j] || bus.PCWr !== 1'b0) begin n_err++; $display("FAIL jmp%0d_exec got=%h/%b exp=%h/0", j, bus.imm_out, bus.PCWr, imms[j]); end
      @(negedge clk); #1;
      n_vec++; if (bus.RegWr !== 1'b1 || bus.PCWr !== 1'b1 || bus.PCSrc !== srcs[j]) begin n_err++; $display("FAIL jmp%0d_wb got=%b%b/%b exp=11/%b", j, bus.RegWr, bus.PCWr, bus.PCSrc, srcs[j]); end
    end
  endtask

  task automatic test_store();
    do_reset();
    fetch_decode(32'h0020A423);
    @(negedge clk); bus.dmem_ready = 1'b1; #1;
    n_vec++; if (bus.dmem_req !== 1'b1 || bus.MemWr !== 1'b1) begin n_err++; $display("FAIL sw_mem got=%b%b exp=11", bus.dmem_req, bus.MemWr); end
    n_vec++; if (bus.PCWr !== 1'b1 || bus.PCSrc !== 2'b00 || bus.RegWr !== 1'b0) begin n_err++; $display("FAIL sw_pc got=%b/%b/%b exp=1/00/0", bus.PCWr, bus.PCSrc, bus.RegWr); end
    @(negedge clk); bus.dmem_ready = 1'b0; #1;
    n_vec++; if (bus.imem_req !== 1'b1 || bus.MemWr !== 1'b0) begin n_err++; $display("FAIL sw_refetch got=%b%b exp=10", bus.imem_req, bus.MemWr); end
  endtask

  task automatic test_store_reset();
    do_reset();
    fetch_decode(32'h0020A423);
    @(negedge clk); #1;
    n_vec++; if (bus.dmem_req !== 1'b1 || bus.MemWr !== 1'b1) begin n_err++; $display("FAIL swr_mem got=%b%b exp=11", bus.dmem_req, bus.MemWr); end
    #2 rst = 1'b1; #1;
    n_vec++; if (bus.dmem_req !== 1'b0 || bus.MemWr !== 1'b0 || bus.imem_req !== 1'b0) begin n_err++; $display("FAIL swr_async got=%b%b%b exp=000", bus.dmem_req, bus.MemWr, bus.imem_req); end
    n_vec++; if (bus.MemOp !== 3'b000 || bus.imm_out !== 32'h0) begin n_err++; $display("FAIL swr_fields got=%b/%h exp=000/0", bus.MemOp, bus.imm_out); end
    @(negedge clk); rst = 1'b0; bus.dmem_ready = 1'b1; #1;
    n_vec++; if (bus.MemWr !== 1'b0 || bus.imem_req !== 1'b0 || bus.PCWr !== 1'b0) begin n_err++; $display("FAIL swr_release got=%b%b%b exp=000", bus.MemWr, bus.imem_req, bus.PCWr); end
    @(negedge clk); #1;
    n_vec++; if (bus.imem_req !== 1'b1 || bus.MemWr !== 1'b0) begin n_err++; $display("FAIL swr_fetch got=%b%b exp=10", bus.imem_req, bus.MemWr); end
    bus.dmem_ready = 1'b0;
  endtask

  task automatic test_imem_timeout();
    int errs = 0;
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      #1;
      if (bus.bus_err === 1'b1) errs++;
      n_vec++; if (bus.IRWr !== 1'b0 || bus.imem_req !== 1'b1) begin n_err++; $display("FAIL ito%0d_req got=%b%b exp=01", k, bus.IRWr, bus.imem_req); end
      n_vec++; if (bus.bus_err !== (k == 15)) begin n_err++; $display("FAIL ito%0d_bus_err got=%b exp=%b", k, bus.bus_err, (k == 15)); end
      @(negedge clk);
    end
    n_vec++; if (errs != 1) begin n_err++; $display("FAIL ito_pulse_count got=%0d exp=1", errs); end
    for (int k = 1; k <= 15; k++) begin
      bus.inst = 32'h002081B3; bus.imem_ready = (k == 15); #1;
      n_vec++; if (bus.bus_err !== 1'b0) begin n_err++; $display("FAIL ready15_%0d_bus_err got=%b exp=0", k, bus.bus_err); end
      n_vec++; if (bus.IRWr !== (k == 15)) begin n_err++; $display("FAIL ready15_%0d_irwr got=%b exp=%b", k, bus.IRWr, (k == 15)); end
      @(negedge clk);
    end
    bus.imem_ready = 1'b0;
  endtask

  task automatic test_dmem_timeout();
    do_reset();
    fetch_decode(32'h0080A283);
    @(negedge clk);
    for (int k = 1; k <= 15; k++) begin
      #1;
      n_vec++; if (bus.bus_err !== (k == 15) || bus.RegWr !== 1'b0) begin n_err++; $display("FAIL dto%0d got=%b%b exp=%b0", k, bus.bus_err, bus.RegWr, (k == 15)); end
      @(negedge clk);
    end
    #1;
    n_vec++; if (bus.imem_req !== 1'b1 || bus.PCWr !== 1'b0) begin n_err++; $display("FAIL dto_refetch got=%b%b exp=10", bus.imem_req, bus.PCWr); end
  endtask

  task automatic test_illegal();
    logic [31:0] bad [2];
    bad[0] = 32'h0000007F; bad[1] = 32'h40001033;
    for (int j = 0; j < 2; j++) begin
      do_reset();
      fetch_decode(bad[j]);
`ifdef ILLEGAL_TRAP_EN
      for (int k = 0; k < 5; k++) begin
        #1;
        n_vec++; if (bus.trap !== 1'b1) begin n_err++; $display("FAIL ill%0d_trap%0d got=%b exp=1", j, k, bus.trap); end
        n_vec++; if (bus.PCWr !== 1'b0 || bus.RegWr !== 1'b0 || bus.imem_req !== 1'b0) begin n_err++; $display("FAIL ill%0d_quiet%0d got=%b%b%b exp=000", j, k, bus.PCWr, bus.RegWr, bus.imem_req); end
        @(negedge clk);
      end
`else
      #1;
      n_vec++; if (bus.PCWr !== 1'b1 || bus.PCSrc !== 2'b00) begin n_err++; $display("FAIL ill%0d_nop_pc got=%b/%b exp=1/00", j, bus.PCWr, bus.PCSrc); end
      n_vec++; if (bus.RegWr !== 1'b0 || bus.dmem_req !== 1'b0) begin n_err++; $display("FAIL ill%0d_nop_quiet got=%b%b exp=00", j, bus.RegWr, bus.dmem_req); end
      @(negedge clk); #1;
      n_vec++; if (bus.imem_req !== 1'b1 || bus.PCWr !== 1'b0) begin n_err++; $display("FAIL ill%0d_refetch got=%b%b exp=10", j, bus.imem_req, bus.PCWr); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.inst = 32'h002081B3; bus.imem_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      #1;
      n_vec++; if (bus.IRWr !== ((k - 1) % 4 == 0)) begin n_err++; $display("FAIL b2b%0d_irwr got=%b exp=%b", k, bus.IRWr, ((k - 1) % 4 == 0)); end
      n_vec++; if (bus.RegWr !== (k % 4 == 0)) begin n_err++; $display("FAIL b2b%0d_regwr got=%b exp=%b", k, bus.RegWr, (k % 4 == 0)); end
      @(negedge clk);
    end
    bus.imem_ready = 1'b0;
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_add();
    test_decode_table();
    test_load_wait();
    test_branch();
    test_jump();
    test_store();
    test_store_reset();
    test_imem_timeout();
    test_dmem_timeout();
    test_illegal();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
